ram_cmd_fetcher: RTL and testbench

//  Downstream consumer of the ROM-to-RAM loader. Waits for the loader's finish

---
 rtl/ram_cmd_fetcher.sv | 155 +++++++++++++++
 tb/tb_ram_cmd_fetcher.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_cmd_fetcher.sv
// +----------------------------------------------------------------------------+
// | Module  : ram_cmd_fetcher                                                  |
// | Purpose : Scans loader RAM words 0..NUM_WORDS-1 into a valid/ready stream.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram_cmd_fetcher #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_WORDS    = 7,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  loader_finish,
  input  logic                  rescan,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [DATA_WIDTH-1:0] cmd_data,
  output logic [ADDR_WIDTH-1:0] cmd_index,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Terminal address compared at full address width so NUM_WORDS == 2**ADDR_WIDTH works.
  localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [1:0]            c_WAIT_INIT = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   w_addr_nxt;
  logic [1:0]              r_wait;
  logic [1:0]              w_wait_nxt;
  logic                    r_cmd_valid;
  logic                    w_cmd_valid_nxt;
  logic [DATA_WIDTH-1:0]   r_cmd_data;
  logic [DATA_WIDTH-1:0]   w_cmd_data_nxt;
  logic [ADDR_WIDTH-1:0]   r_cmd_index;
  logic [ADDR_WIDTH-1:0]   w_cmd_index_nxt;
  logic                    r_busy;
  logic                    w_busy_nxt;
  logic                    r_done;
  logic                    w_done_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wait      <= 2'd0;
      r_cmd_valid <= 1'b0;
      r_cmd_data  <= '0;
      r_cmd_index <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_wait      <= w_wait_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_cmd_data  <= w_cmd_data_nxt;
      r_cmd_index <= w_cmd_index_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_wait_nxt      = r_wait;
    w_cmd_valid_nxt = r_cmd_valid;
    w_cmd_data_nxt  = r_cmd_data;
    w_cmd_index_nxt = r_cmd_index;

    case (r_state)
      S_IDLE: begin
        if (loader_finish) begin
          w_state_nxt = S_ISSUE;
          w_addr_nxt  = '0;
        end
      end
      S_ISSUE: begin
        if (READ_LATENCY == 0) begin
          w_cmd_valid_nxt = 1'b1;
          w_cmd_data_nxt  = ram_read_data;
          w_cmd_index_nxt = r_addr;
          w_state_nxt     = S_HOLD;
        end else begin
          w_wait_nxt  = c_WAIT_INIT;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_wait == 2'd0) begin
          w_cmd_valid_nxt = 1'b1;
          w_cmd_data_nxt  = ram_read_data;
          w_cmd_index_nxt = r_addr;
          w_state_nxt     = S_HOLD;
        end else begin
          w_wait_nxt = r_wait - 2'd1;
        end
      end
      S_HOLD: begin
        // Payload is frozen until the downstream handshake completes.
        if (cmd_ready) begin
          w_cmd_valid_nxt = 1'b0;
          if (r_addr == c_LAST_ADDR) begin
            w_state_nxt = S_DONE;
          end else begin
            w_addr_nxt  = r_addr + c_ADDR_ONE;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        if (rescan) begin
          w_addr_nxt  = '0;
          w_state_nxt = S_ISSUE;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_addr_nxt      = '0;
        w_wait_nxt      = 2'd0;
        w_cmd_valid_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT) || (w_state_nxt == S_HOLD);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  assign ram_read_addr = r_busy ? r_addr : '0;
  assign cmd_valid     = r_cmd_valid;
  assign cmd_data      = r_cmd_data;
  assign cmd_index     = r_cmd_index;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ram_cmd_fetcher.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_ram_cmd_fetcher                                               |
// | Purpose : Several fetcher configurations against a cycle-age scan model.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ram_cmd_fetcher;

  localparam int c_NI = 5;

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      2:       return 2;
      3:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int nw_of(input int i);
    return (i == 4) ? 1 : 7;
  endfunction

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic loader_finish = 1'b0;
  logic rescan = 1'b0;
  logic cmd_ready = 1'b1;

  logic [7:0]  rd_addr   [c_NI];
  logic [31:0] rd_data   [c_NI];
  logic        cmd_valid [c_NI];
  logic [31:0] cmd_data  [c_NI];
  logic [7:0]  cmd_index [c_NI];
  logic        busy      [c_NI];
  logic        done      [c_NI];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < c_NI; g++) begin : g_dut
    localparam int L = lat_of(g);
    ram_cmd_fetcher #(
      .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_WORDS(nw_of(g)), .READ_LATENCY(L)
    ) u_dut (
      .clk(clk), .reset(reset), .loader_finish(loader_finish), .rescan(rescan),
      .ram_read_addr(rd_addr[g]), .ram_read_data(rd_data[g]),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready), .cmd_data(cmd_data[g]),
      .cmd_index(cmd_index[g]), .busy(busy[g]), .done(done[g])
    );
    // RAM model: mem[a] = A000_0000 + a, delivered L cycles after the address.
    if (L == 0) begin : g_comb
      assign rd_data[g] = 32'hA000_0000 + 32'(rd_addr[g]);
    end else begin : g_pipe
      logic [31:0] pipe [L];
      always @(posedge clk) begin
        pipe[0] <= 32'hA000_0000 + 32'(rd_addr[g]);
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
      end
      assign rd_data[g] = pipe[L-1];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scan model: each word is "aged" from its issue cycle; it is presented once
  // its age reaches L+1 and leaves on a handshake.
  bit          m_active [c_NI];
  bit          m_done   [c_NI];
  int          m_addr   [c_NI];
  int          m_age    [c_NI];
  logic [31:0] m_data   [c_NI];
  logic [7:0]  m_idx    [c_NI];

  always @(posedge clk) begin
    for (int i = 0; i < c_NI; i++) begin
      if (reset) begin
        m_active[i] = 0; m_done[i] = 0; m_addr[i] = 0; m_age[i] = 0;
        m_data[i] = 32'h0; m_idx[i] = 8'h0;
      end else if (!m_active[i] && !m_done[i]) begin
        if (loader_finish) begin m_active[i] = 1; m_addr[i] = 0; m_age[i] = 0; end
      end else if (m_done[i]) begin
        if (rescan) begin m_done[i] = 0; m_active[i] = 1; m_addr[i] = 0; m_age[i] = 0; end
      end else if (m_age[i] == lat_of(i) + 1) begin
        if (cmd_ready) begin
          if (m_addr[i] == nw_of(i) - 1) begin m_active[i] = 0; m_done[i] = 1; end
          else begin m_addr[i]++; m_age[i] = 0; end
        end
      end else begin
        m_age[i]++;
        if (m_age[i] == lat_of(i) + 1) begin
          m_data[i] = 32'hA000_0000 + 32'(m_addr[i]);
          m_idx[i]  = 8'(m_addr[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < c_NI; i++) begin
        check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_active[i]));
        check($sformatf("done[%0d]", i), 32'(done[i]), 32'(m_done[i]));
        check($sformatf("valid[%0d]", i), 32'(cmd_valid[i]),
              32'(m_active[i] && (m_age[i] == lat_of(i) + 1)));
        check($sformatf("addr[%0d]", i), 32'(rd_addr[i]), m_active[i] ? 32'(m_addr[i]) : 32'h0);
        check($sformatf("data[%0d]", i), cmd_data[i], m_data[i]);
        check($sformatf("index[%0d]", i), 32'(cmd_index[i]), 32'(m_idx[i]));
      end
    end
  end

  logic [7:0]  hs_idx  [$];
  logic [31:0] hs_data [$];
  always @(negedge clk) begin
    if (!reset && cmd_valid[0] && cmd_ready) begin
      hs_idx.push_back(cmd_index[0]);
      hs_data.push_back(cmd_data[0]);
    end
  end

  function automatic bit all_done();
    for (int i = 0; i < c_NI; i++) if (!done[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_all_done(input int budget);
    int t = 0;
    while (!all_done() && t < budget) begin @(negedge clk); t++; end
    if (!all_done()) check("all_done_timeout", 32'(t), 32'(budget + 1));
  endtask

  task automatic wait_valid0(input string name, input int budget);
    int t = 0;
    while (!cmd_valid[0] && t < budget) begin @(negedge clk); t++; end
    if (!cmd_valid[0]) check(name, 32'(cmd_valid[0]), 32'h1);
  endtask

  task automatic wait_issue0(input int a, input string name, input int budget);
    int t = 0;
    while (!(busy[0] && !cmd_valid[0] && rd_addr[0] == 8'(a)) && t < budget) begin
      @(negedge clk); t++;
    end
    if (t >= budget) check(name, 32'(rd_addr[0]), 32'(a));
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(cmd_valid[0]), 32'h0);
    check("rst_data", cmd_data[0], 32'h0);

    // Idle with finish low: nothing happens.
    repeat (8) @(negedge clk);
    check("idle_busy", 32'(busy[0]), 32'h0);
    check("idle_addr", 32'(rd_addr[0]), 32'h0);

    // Full scan at L=1 with ready held high.
    hs_idx.delete(); hs_data.delete();
    @(posedge clk); #1 loader_finish = 1'b1;
    t = 0;
    while (!busy[0] && t < 10) begin @(negedge clk); t++; end
    t = 0;
    while (!done[0] && t < 100) begin @(negedge clk); t++; end
    check("done_cycle", 32'(t), 32'd21);
    check("scan1_count", 32'(hs_idx.size()), 32'd7);
    if (hs_idx.size() == 7) begin
      check("scan1_first", hs_data[0], 32'hA000_0000);
      check("scan1_last", hs_data[6], 32'hA000_0006);
      check("scan1_lastidx", 32'(hs_idx[6]), 32'd6);
    end
    wait_all_done(200);

    // Rescan from DONE with a stall on word 3 and finish dropped mid-scan.
    hs_idx.delete(); hs_data.delete();
    @(posedge clk); #1 rescan = 1'b1;
    @(posedge clk); #1 rescan = 1'b0;
    @(negedge clk);
    check("rescan_done", 32'(done[0]), 32'h0);
    check("rescan_busy", 32'(busy[0]), 32'h1);
    wait_issue0(3, "issue3_timeout", 50);
    cmd_ready = 1'b0;
    loader_finish = 1'b0;
    wait_valid0("stall_valid_timeout", 10);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 32'(cmd_valid[0]), 32'h1);
      check("stall_data", cmd_data[0], 32'hA000_0003);
      check("stall_addr", 32'(rd_addr[0]), 32'h3);
      rescan = (k == 2);
      @(negedge clk);
    end
    rescan = 1'b0;
    cmd_ready = 1'b1;
    wait_all_done(200);
    check("scan2_count", 32'(hs_idx.size()), 32'd7);
    for (int k = 0; k < hs_data.size(); k++)
      check("scan2_data", hs_data[k], 32'hA000_0000 + 32'(k));

    // Reset during WAIT of word 4, then restart from index 0.
    @(posedge clk); #1 loader_finish = 1'b1; rescan = 1'b1;
    @(posedge clk); #1 rescan = 1'b0;
    wait_issue0(4, "issue4_timeout", 50);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("wait4_addr", 32'(rd_addr[0]), 32'h4);
    @(negedge clk);
    check("rst_busy", 32'(busy[0]), 32'h0);
    check("rst_valid2", 32'(cmd_valid[0]), 32'h0);
    check("rst_index", 32'(cmd_index[0]), 32'h0);
    check("rst_data2", cmd_data[0], 32'h0);
    check("rst_addr", 32'(rd_addr[0]), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    wait_valid0("restart_timeout", 20);
    check("restart_index", 32'(cmd_index[0]), 32'h0);
    check("restart_data", cmd_data[0], 32'hA000_0000);
    wait_all_done(200);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      reset     = ($urandom_range(0, 299) == 0);
      cmd_ready = ($urandom_range(0, 3) != 0);
      rescan    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) loader_finish = ~loader_finish;
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
